ex_mem_skid: RTL and testbench
==============================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the width of PC, ALU result, rs2 data and immediate.
REQ-002 The block SHALL have parameter CTRL_W, default 11, the width of the packed control bundle: [0] MemWrite, [3:1] NPCOp, [6:4] DMType, [7] RegWrite, [10:8] WDSel.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the EX stage presents a valid instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: registered; the block accepts this cycle.
REQ-007 The block SHALL have ports in_pc, in_alures, in_rs2_data and in_imm, inputs, XLEN bits each: the EX payload.
REQ-008 The block SHALL have port in_inst, input, 32 bits: the instruction word.
REQ-009 The block SHALL have port in_rd, input, 5 bits: the destination register.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W bits: the MEM/WB control bundle.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all held and incoming entries.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the head entry is valid toward MEM.
REQ-013 The block SHALL have port out_ready, input, 1 bit: MEM consumes the head; low means stall.
REQ-014 The block SHALL have ports out_pc, out_inst, out_rd, out_alures, out_rs2_data, out_imm and out_ctrl, outputs, matching the input widths: the head payload.
REQ-015 The block SHALL have port count, output, 2 bits: occupancy, 0..2.

Function
REQ-016 The block SHALL be a 2-entry in-order buffer (head + skid) passing one instruction per cycle at full throughput, with in_ready driven only from a register.
REQ-017 A push SHALL occur iff in_valid && in_ready && !flush, and a pop SHALL occur iff out_valid && out_ready && !flush.
REQ-018 in_ready SHALL equal (count < 2) as registered state; with count 1 and a simultaneous push and pop it SHALL stay 1.
REQ-019 Latency SHALL be one cycle: a push at edge k into an empty buffer gives out_valid=1 with that payload after edge k.
REQ-020 Count transitions SHALL be: push only +1; pop only -1; push+pop unchanged with the head replaced by the next-oldest entry; neither unchanged.
REQ-021 A push at count 2 SHALL be impossible, since in_ready=0; in_valid in that state SHALL be ignored with no state change.
REQ-022 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-023 out_valid SHALL equal (count != 0).
REQ-024 When count is 0, out_ctrl SHALL be all-zero (bubble: MemWrite=0, RegWrite=0) and all other out_* payloads SHALL be zero.
REQ-025 A pop that empties the buffer SHALL clear the head payload to zero.
REQ-026 A flush SHALL, at the next edge, set count=0, zero all payload registers and set in_ready=1; flush SHALL take priority over any push or pop in the same cycle, and that push SHALL be lost.
REQ-027 Entry order SHALL be strictly FIFO; the skid entry SHALL move to the head on the pop that frees the head.

Reset
REQ-028 On rst=1 at a rising edge, the block SHALL set count=0, out_valid=0, in_ready=1 and all out_* payload and out_ctrl to 0.
REQ-029 rst SHALL dominate flush, push and pop.
REQ-030 rst asserted mid-operation with 2 entries held SHALL discard both entries, with no partial output afterwards.

Verification
REQ-031 The bench SHALL cover streaming: out_ready=1, push pc=0x100,0x104,0x108 on consecutive cycles -> out_pc 0x100,0x104,0x108 one cycle later each, count stays 1, in_ready stays 1.
REQ-032 The bench SHALL cover a stall: out_ready=0, push A (alures=0xA) then B (0xB) -> count=2, in_ready=0 next cycle, out_alures holds 0xA; then out_ready=1 -> A, then B, then count=0.
REQ-033 The bench SHALL cover full-plus-input: count=2 with in_valid=1 carrying C -> C not accepted and no state change; C is accepted once in_ready returns to 1.
REQ-034 The bench SHALL cover flush collision: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_ctrl=0, in_ready=1, nothing delivered.
REQ-035 The bench SHALL cover a bubble check: empty buffer -> out_ctrl[0]=0 and out_ctrl[7]=0; push in_ctrl=0x081 -> out_ctrl=0x081.
REQ-036 The bench SHALL cover reset mid-operation: count=2 and rst=1 for one cycle -> all outputs 0, count=0, in_ready=1; the first push after reset emerges unchanged.

Source files
------------

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register as a 2-entry head+skid buffer.
// in_ready comes straight from a flop; the skid absorbs one late stall.
module ex_mem_skid #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  input  logic [4:0]        in_rd,
  input  logic [XLEN-1:0]   in_alures,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_alures,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic [4:0]        rd;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  ent_t       head_q, head_d;
  ent_t       skid_q, skid_d;
  ent_t       in_ent;
  logic [1:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;
  logic       push, pop;

  assign in_ent = '{
    pc:   in_pc,
    inst: in_inst,
    rd:   in_rd,
    alu:  in_alures,
    rs2:  in_rs2_data,
    imm:  in_imm,
    ctrl: in_ctrl
  };

  assign out_valid = (cnt_q != 2'd0);
  assign push = in_valid && rdy_q && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      skid_d = '0;
      cnt_d  = 2'd0;
    end else begin
      unique case (cnt_q)
        2'd0: begin
          if (push) begin
            head_d = in_ent;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_ent;
          end else if (push) begin
            skid_d = in_ent;
            cnt_d  = 2'd2;
          end else if (pop) begin
            head_d = '0;
            cnt_d  = 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            head_d = skid_q;
            skid_d = '0;
            cnt_d  = 2'd1;
          end
        end
        default: begin
          head_d = '0;
          skid_d = '0;
          cnt_d  = 2'd0;
        end
      endcase
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b1;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready     = rdy_q;
  assign count        = cnt_q;
  assign out_pc       = head_q.pc;
  assign out_inst     = head_q.inst;
  assign out_rd       = head_q.rd;
  assign out_alures   = head_q.alu;
  assign out_rs2_data = head_q.rs2;
  assign out_imm      = head_q.imm;
  assign out_ctrl     = head_q.ctrl;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_ex_mem_skid;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 11;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_inst;
  logic [4:0]        in_rd;
  logic [XLEN-1:0]   in_alures;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_inst;
  logic [4:0]        out_rd;
  logic [XLEN-1:0]   out_alures;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        count;

  int n_vec;
  int n_err;

  ex_mem_skid #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_rd        (in_rd),
    .in_alures    (in_alures),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_ctrl      (in_ctrl),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_rd       (out_rd),
    .out_alures   (out_alures),
    .out_rs2_data (out_rs2_data),
    .out_imm      (out_imm),
    .out_ctrl     (out_ctrl),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction; other fields derive from pc/alu.
  task automatic drive(input logic [31:0] pc,
                       input logic [31:0] alu,
                       input logic [10:0] ctrl);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_inst     = pc ^ 32'h0000_0013;
    in_rd       = pc[6:2];
    in_alures   = alu;
    in_rs2_data = alu + 32'd1;
    in_imm      = pc + 32'd4;
    in_ctrl     = ctrl;
  endtask

  task automatic idle_in;
    in_valid    = 1'b0;
    in_pc       = '0;
    in_inst     = '0;
    in_rd       = '0;
    in_alures   = '0;
    in_rs2_data = '0;
    in_imm      = '0;
    in_ctrl     = '0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".cnt"},  count,        2'd0);
    chk({tag, ".ov"},   out_valid,    1'b0);
    chk({tag, ".ir"},   in_ready,     1'b1);
    chk({tag, ".pc"},   out_pc,       32'd0);
    chk({tag, ".inst"}, out_inst,     32'd0);
    chk({tag, ".rd"},   out_rd,       5'd0);
    chk({tag, ".alu"},  out_alures,   32'd0);
    chk({tag, ".rs2"},  out_rs2_data, 32'd0);
    chk({tag, ".imm"},  out_imm,      32'd0);
    chk({tag, ".ctrl"}, out_ctrl,     11'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();

    // reset, with a push offered to show rst dominates
    drive(32'h0000_0AA0, 32'h55, 11'h7FF);
    tick();
    rst = 1'b0;
    idle_in();
    chk_empty("rst");
    chk("bub.mw", out_ctrl[0], 1'b0);
    chk("bub.rw", out_ctrl[7], 1'b0);

    // bubble then one real entry with ctrl 0x081
    drive(32'h0000_0040, 32'h1234, 11'h081);
    tick();
    idle_in();
    chk("bub.ctrl", out_ctrl, 11'h081);
    chk("bub.cnt", count, 2'd1);
    chk("bub.ov", out_valid, 1'b1);
    chk("bub.pc", out_pc, 32'h40);
    chk("bub.inst", out_inst, 32'h53);
    chk("bub.rd", out_rd, 5'd16);
    chk("bub.rs2", out_rs2_data, 32'h1235);
    chk("bub.imm", out_imm, 32'h44);
    out_ready = 1'b1;
    tick();
    chk_empty("drain");

    // streaming at full rate
    drive(32'h100, 32'h1, 11'h080);
    tick();
    chk("st0.pc", out_pc, 32'h100);
    chk("st0.cnt", count, 2'd1);
    chk("st0.ir", in_ready, 1'b1);
    drive(32'h104, 32'h2, 11'h080);
    tick();
    chk("st1.pc", out_pc, 32'h104);
    chk("st1.cnt", count, 2'd1);
    chk("st1.ir", in_ready, 1'b1);
    drive(32'h108, 32'h3, 11'h080);
    tick();
    chk("st2.pc", out_pc, 32'h108);
    chk("st2.cnt", count, 2'd1);
    chk("st2.ir", in_ready, 1'b1);
    idle_in();
    tick();
    chk_empty("st.end");

    // stall fills the skid
    out_ready = 1'b0;
    drive(32'h200, 32'hA, 11'h001);
    tick();
    chk("stl.a.alu", out_alures, 32'hA);
    chk("stl.a.cnt", count, 2'd1);
    chk("stl.a.ir", in_ready, 1'b1);
    drive(32'h204, 32'hB, 11'h002);
    tick();
    idle_in();
    chk("stl.b.cnt", count, 2'd2);
    chk("stl.b.ir", in_ready, 1'b0);
    chk("stl.b.alu", out_alures, 32'hA);
    chk("stl.b.pc", out_pc, 32'h200);
    tick();
    chk("stl.hold.alu", out_alures, 32'hA);
    chk("stl.hold.ctrl", out_ctrl, 11'h001);
    chk("stl.hold.cnt", count, 2'd2);

    // full with C offered: ignored
    drive(32'h208, 32'hC, 11'h004);
    tick();
    chk("full.cnt", count, 2'd2);
    chk("full.alu", out_alures, 32'hA);
    chk("full.ir", in_ready, 1'b0);
    // release: A pops, B to head, C still refused
    out_ready = 1'b1;
    tick();
    chk("rel.b.alu", out_alures, 32'hB);
    chk("rel.b.pc", out_pc, 32'h204);
    chk("rel.b.ctrl", out_ctrl, 11'h002);
    chk("rel.b.cnt", count, 2'd1);
    chk("rel.b.ir", in_ready, 1'b1);
    // B pops while C pushes
    tick();
    idle_in();
    chk("rel.c.alu", out_alures, 32'hC);
    chk("rel.c.pc", out_pc, 32'h208);
    chk("rel.c.cnt", count, 2'd1);
    tick();
    chk_empty("rel.end");

    // flush collides with push and pop at count 2
    out_ready = 1'b0;
    drive(32'h400, 32'hD, 11'h081);
    tick();
    drive(32'h404, 32'hE, 11'h081);
    tick();
    chk("fl.pre.cnt", count, 2'd2);
    drive(32'h408, 32'hF, 11'h081);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    chk_empty("fl");
    tick();
    chk_empty("fl.lost");

    // reset with two entries held
    out_ready = 1'b0;
    drive(32'h500, 32'h11, 11'h0FF);
    tick();
    drive(32'h504, 32'h22, 11'h0FF);
    tick();
    chk("rm.pre.cnt", count, 2'd2);
    idle_in();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk_empty("rm");
    drive(32'h300, 32'h77, 11'h123);
    tick();
    idle_in();
    chk("rm.i.pc", out_pc, 32'h300);
    chk("rm.i.alu", out_alures, 32'h77);
    chk("rm.i.ctrl", out_ctrl, 11'h123);
    chk("rm.i.cnt", count, 2'd1);
    out_ready = 1'b1;
    tick();
    chk_empty("rm.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
